// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// The result is computed into shadow registers when an op is accepted and copied
// to HI/LO on the last busy edge, so HI/LO stay stable while Busy is high.
// Optional feature: define MDU_MADD_EN to enable MDUOp 111 (madd, {HI,LO} += A*B).
module mdu_unit #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       MDUOp,
  input  logic             Start,
  output logic             Busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  typedef enum logic {StIdle, StRun} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic [WIDTH-1:0]  hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0]  shi_q, shi_d, slo_q, slo_d;
  logic              wr_q, wr_d;
`ifdef MDU_MADD_EN
  logic              acc_q, acc_d;
`endif

  logic                   is_mul, is_div, is_madd, long_op, accept, last;
  logic [2*WIDTH-1:0]     prod_s, prod_u;
  logic                   sdiv_ovf;
  logic [WIDTH-1:0]       sdiv_b, udiv_b;
  logic [WIDTH-1:0]       quot_s, rem_s, quot_u, rem_u;

  // Op decode and combinational datapath for the shadow result.
  always_comb begin
    is_mul  = (MDUOp == 3'b001) || (MDUOp == 3'b010);
    is_div  = (MDUOp == 3'b011) || (MDUOp == 3'b100);
`ifdef MDU_MADD_EN
    is_madd = (MDUOp == 3'b111);
`else
    is_madd = 1'b0;
`endif
    long_op = is_mul || is_div || is_madd;
    accept  = Start && (state_q == StIdle);
    last    = (state_q == StRun) && (cnt_q == CntW'(1));

    prod_s  = $signed({{WIDTH{A[WIDTH-1]}}, A}) * $signed({{WIDTH{B[WIDTH-1]}}, B});
    prod_u  = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};

    // Dividing MIN by 1 instead of -1 yields exactly quotient=A, remainder=0, and a
    // divisor of 1 on B=0 keeps the datapath defined (the result is discarded anyway).
    sdiv_ovf = (A == {1'b1, {(WIDTH-1){1'b0}}}) && (B == {WIDTH{1'b1}});
    sdiv_b   = ((B == '0) || sdiv_ovf) ? WIDTH'(1) : B;
    udiv_b   = (B == '0) ? WIDTH'(1) : B;
    quot_s   = $signed(A) / $signed(sdiv_b);
    rem_s    = $signed(A) % $signed(sdiv_b);
    quot_u   = A / udiv_b;
    rem_u    = A % udiv_b;
  end

  // Next-state logic: IDLE loads the cycle counter on a long op, RUN counts down.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    unique case (state_q)
      StIdle: begin
        if (accept && long_op) begin
          state_d = StRun;
          cnt_d   = is_div ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
          busy_d  = 1'b1;
        end
      end
      StRun: begin
        cnt_d = cnt_q - CntW'(1);
        if (last) begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output logic: shadow capture on accept, HI/LO writes from mthi/mtlo or final RUN edge.
  always_comb begin
    hi_d  = hi_q;
    lo_d  = lo_q;
    shi_d = shi_q;
    slo_d = slo_q;
    wr_d  = wr_q;
`ifdef MDU_MADD_EN
    acc_d = acc_q;
`endif
    if (accept) begin
`ifdef MDU_MADD_EN
      acc_d = 1'b0;
`endif
      case (MDUOp)
        3'b001: begin {shi_d, slo_d} = prod_s; wr_d = 1'b1; end
        3'b010: begin {shi_d, slo_d} = prod_u; wr_d = 1'b1; end
        3'b011: begin slo_d = quot_s; shi_d = rem_s; wr_d = (B != '0); end
        3'b100: begin slo_d = quot_u; shi_d = rem_u; wr_d = (B != '0); end
        3'b101: hi_d = A;
        3'b110: lo_d = A;
`ifdef MDU_MADD_EN
        3'b111: begin {shi_d, slo_d} = prod_s; wr_d = 1'b1; acc_d = 1'b1; end
`endif
        default: ;
      endcase
    end
    if (last && wr_q) begin
`ifdef MDU_MADD_EN
      // Accumulator is read at write time; nothing else can touch HI/LO while busy.
      if (acc_q) {hi_d, lo_d} = {hi_q, lo_q} + {shi_q, slo_q};
      else       {hi_d, lo_d} = {shi_q, slo_q};
`else
      {hi_d, lo_d} = {shi_q, slo_q};
`endif
    end
  end

  // State register with synchronous reset; reset discards any in-flight result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      shi_q   <= '0;
      slo_q   <= '0;
      wr_q    <= 1'b0;
`ifdef MDU_MADD_EN
      acc_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      shi_q   <= shi_d;
      slo_q   <= slo_d;
      wr_q    <= wr_d;
`ifdef MDU_MADD_EN
      acc_q   <= acc_d;
`endif
    end
  end

  assign Busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Scoreboard bench for mdu_unit: the driver pushes expected {HI,LO} pairs, the
// monitor pops and compares when Busy falls or when the driver raises a probe.
module tb_mdu_unit;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] A, B;
  logic [2:0]   MDUOp;
  logic         Start;
  logic         Busy;
  logic [W-1:0] HI, LO;

  logic [2*W-1:0] sb[$];
  logic           probe;
  int             n_vec  = 0;
  int             n_miss = 0;

  mdu_unit #(.WIDTH(W), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .A     (A),
    .B     (B),
    .MDUOp (MDUOp),
    .Start (Start),
    .Busy  (Busy),
    .HI    (HI),
    .LO    (LO)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare HI/LO against the scoreboard whenever a result is presented.
  initial begin : monitor
    logic           busy_prev;
    logic [2*W-1:0] e;
    busy_prev = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if ((busy_prev && !Busy) || probe) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL scoreboard_empty: got HI/LO %h%h with no expectation queued", HI, LO);
        end else begin
          e = sb.pop_front();
          check("hilo", {HI, LO}, e);
        end
      end
      busy_prev = Busy;
    end
  end

  // Issue one request; returns at the negedge after the accepting edge.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    A = a; B = b; MDUOp = op; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0; MDUOp = 3'b000;
  endtask

  task automatic pulse_probe();
    probe = 1'b1;
    @(negedge clk);
    probe = 1'b0;
  endtask

  // Count busy cycles (bounded) and check HI/LO hold still while busy.
  task automatic wait_done(input string name, input int exp_n, input int n_start);
    int             n;
    logic           held;
    logic [2*W-1:0] hold;
    n    = n_start;
    held = 1'b1;
    hold = {HI, LO};
    while (Busy && n < 100) begin
      if ({HI, LO} !== hold) held = 1'b0;
      n++;
      @(negedge clk);
    end
    check({name, "_busy_len"}, 64'(n), 64'(exp_n));
    check({name, "_hold"}, 64'(held), 64'd1);
  endtask

  initial begin : driver
    logic seen42;
    reset = 1'b1; A = '0; B = '0; MDUOp = 3'b000; Start = 1'b0; probe = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_busy", 64'(Busy), 64'd0);
    sb.push_back({32'h0, 32'h0});
    pulse_probe();

    // mult / multu of -2 * 3
    sb.push_back({32'hFFFFFFFF, 32'hFFFFFFFA});
    issue(3'b001, 32'hFFFFFFFE, 32'd3);
    wait_done("mult", 5, 0);
    sb.push_back({32'h00000002, 32'hFFFFFFFA});
    issue(3'b010, 32'hFFFFFFFE, 32'd3);
    wait_done("multu", 5, 0);

    // Signed division, sign cases and overflow
    sb.push_back({32'hFFFFFFFF, 32'hFFFFFFFD});
    issue(3'b011, 32'hFFFFFFF9, 32'd2);
    wait_done("div_neg", 10, 0);
    sb.push_back({32'h00000001, 32'hFFFFFFFD});
    issue(3'b011, 32'd7, 32'hFFFFFFFE);
    wait_done("div_negdiv", 10, 0);
    sb.push_back({32'h00000000, 32'h80000000});
    issue(3'b011, 32'h80000000, 32'hFFFFFFFF);
    wait_done("div_ovf", 10, 0);
    sb.push_back({32'h00000002, 32'h0000000E});
    issue(3'b100, 32'd100, 32'd7);
    wait_done("divu", 10, 0);

    // mthi / mtlo: single-cycle, no Busy
    issue(3'b101, 32'h11, 32'h0);
    check("mthi_busy", 64'(Busy), 64'd0);
    sb.push_back({32'h11, 32'h0000000E});
    pulse_probe();
    issue(3'b110, 32'h22, 32'h0);
    check("mtlo_busy", 64'(Busy), 64'd0);
    sb.push_back({32'h11, 32'h22});
    pulse_probe();

    // divu by zero, with a mult Start during Busy that must be ignored
    sb.push_back({32'h11, 32'h22});
    issue(3'b100, 32'd50, 32'd0);
    A = 32'd6; B = 32'd7; MDUOp = 3'b001; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0; MDUOp = 3'b000;
    wait_done("divzero", 10, 1);
    @(negedge clk);
    check("ignored_start_busy", 64'(Busy), 64'd0);

    // Reset in busy cycle 3 of mult 6*7
    issue(3'b001, 32'd6, 32'd7);
    @(negedge clk);
    @(negedge clk);
    check("midop_busy", 64'(Busy), 64'd1);
    sb.push_back({32'h0, 32'h0});
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midop_reset_busy", 64'(Busy), 64'd0);
    seen42 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (LO == 32'd42 || Busy) seen42 = 1'b1;
      @(negedge clk);
    end
    check("midop_no_result", 64'(seen42), 64'd0);

    // madd sequence
    issue(3'b110, 32'd10, 32'd0);
    issue(3'b101, 32'd0, 32'd0);
`ifdef MDU_MADD_EN
    sb.push_back({32'd0, 32'd22});
    issue(3'b111, 32'd3, 32'd4);
    wait_done("madd", 5, 0);
`else
    issue(3'b111, 32'd3, 32'd4);
    check("madd_off_busy", 64'(Busy), 64'd0);
    sb.push_back({32'd0, 32'd10});
    pulse_probe();
`endif

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
